// File: rtl/mmm_exp_datapath.sv
// Modular-exponentiation datapath: two bit-serial Montgomery multipliers plus X/P/result registers.
// Optional schedule checker (sched_err output) enabled by defining MMM_SCHED_CHECK_EN.
module mmm_exp_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             rst_mmm,
  input  logic             ld_a,
  input  logic             ld_r,
  input  logic             lock1,
  input  logic             lock2,
  input  logic [1:0]       sel1,
  input  logic             sel2,
  input  logic             eoc,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] modn,
  input  logic [WIDTH-1:0] r2_mod,
  output logic [WIDTH-1:0] result,
  output logic             done
`ifdef MMM_SCHED_CHECK_EN
  ,
  output logic             sched_err
`endif
);

  localparam int SW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  // One Montgomery iteration; S stays below 2N so the sum fits in SW+1 bits.
  function automatic logic [SW-1:0] mont_step(input logic [SW-1:0] s, input logic a0,
                                              input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] n);
    logic [SW:0] t;
    t = {1'b0, s} + (a0 ? (SW+1)'(b) : '0);
    if (t[0]) t = t + (SW+1)'(n);
    return t[SW:1];
  endfunction

  function automatic logic [WIDTH-1:0] mont_reduce(input logic [SW-1:0] s, input logic [WIDTH-1:0] n);
    return WIDTH'((s >= SW'(n)) ? (s - SW'(n)) : s);
  endfunction

  logic [WIDTH-1:0] r_a1, r_a2, r_b1, r_b2, r_n;
  logic [SW-1:0]    r_s1, r_s2;
  logic [CW-1:0]    r_cnt1, r_cnt2;
  logic [WIDTH-1:0] r_x, r_p, r_result;
  logic             r_done;

  logic [WIDTH-1:0] w_a1, w_b1, w_a2, w_b2, w_f1, w_f2, w_x_next, w_p_next;
  logic             w_wr;

  always_comb begin
    w_a1 = r_x;
    w_b1 = WIDTH'(1);
    case (sel1)
      2'b00:   w_a1 = r2_mod;
      2'b01:   w_b1 = r_p;
      default: w_b1 = WIDTH'(1);
    endcase
    w_a2 = sel2 ? r_p : msg;
    w_b2 = sel2 ? r_p : r2_mod;
  end

  assign w_f1     = mont_reduce(r_s1, r_n);
  assign w_f2     = mont_reduce(r_s2, r_n);
  assign w_wr     = en && rst_mmm && !ld_a && ld_r;
  assign w_x_next = (w_wr && lock1) ? w_f1 : r_x;
  assign w_p_next = (w_wr && lock2) ? w_f2 : r_p;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_a1 <= '0; r_a2 <= '0; r_b1 <= '0; r_b2 <= '0; r_n <= '0;
      r_s1 <= '0; r_s2 <= '0; r_cnt1 <= '0; r_cnt2 <= '0;
    end else if (en) begin
      if (!rst_mmm) begin
        r_s1 <= '0; r_s2 <= '0; r_cnt1 <= '0; r_cnt2 <= '0;
      end else if (ld_a) begin
        r_a1 <= w_a1; r_b1 <= w_b1;
        r_a2 <= w_a2; r_b2 <= w_b2;
        r_n  <= modn;
        r_s1 <= '0; r_s2 <= '0; r_cnt1 <= '0; r_cnt2 <= '0;
      end else if (!ld_r) begin
        if (r_cnt1 < CNT_MAX) begin
          r_s1   <= mont_step(r_s1, r_a1[0], r_b1, r_n);
          r_a1   <= r_a1 >> 1;
          r_cnt1 <= r_cnt1 + CW'(1);
        end
        if (r_cnt2 < CNT_MAX) begin
          r_s2   <= mont_step(r_s2, r_a2[0], r_b2, r_n);
          r_a2   <= r_a2 >> 1;
          r_cnt2 <= r_cnt2 + CW'(1);
        end
      end
    end
  end

  // result captures X as it leaves this edge, so eoc alongside ld_r sees the new X.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_x <= '0; r_p <= '0; r_result <= '0; r_done <= 1'b0;
    end else begin
      r_x <= w_x_next;
      r_p <= w_p_next;
      if (en) begin
        r_done <= eoc;
        if (eoc) r_result <= w_x_next;
      end else begin
        r_done <= 1'b0;
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;

`ifdef MMM_SCHED_CHECK_EN
  logic r_sched_err;
  logic w_early;

  assign w_early = (r_cnt1 < CNT_MAX) || (r_cnt2 < CNT_MAX);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sched_err <= 1'b0;
    end else if (en) begin
      if (!rst_mmm) r_sched_err <= 1'b0;
      else if (w_wr && w_early) r_sched_err <= 1'b1;
    end
  end

  assign sched_err = r_sched_err;
`endif

endmodule

// File: tb/tb_mmm_exp_datapath.sv
// Directed bench for mmm_exp_datapath with N=33, R=256, R^2 mod N=31, M=4.
// Checks sched_err as well when MMM_SCHED_CHECK_EN is defined.
module tb_mmm_exp_datapath;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rstb, en, rst_mmm, ld_a, ld_r, lock1, lock2, sel2, eoc;
  logic [1:0]       sel1;
  logic [WIDTH-1:0] msg, modn, r2_mod;
  logic [WIDTH-1:0] result;
  logic             done;
`ifdef MMM_SCHED_CHECK_EN
  logic             sched_err;
`endif

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  mmm_exp_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstb(rstb), .en(en), .rst_mmm(rst_mmm), .ld_a(ld_a), .ld_r(ld_r),
    .lock1(lock1), .lock2(lock2), .sel1(sel1), .sel2(sel2), .eoc(eoc),
    .msg(msg), .modn(modn), .r2_mod(r2_mod), .result(result), .done(done)
`ifdef MMM_SCHED_CHECK_EN
    , .sched_err(sched_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic pulse_rst_mmm;
    rst_mmm = 1'b0;
    tick;
    rst_mmm = 1'b1;
  endtask

  task automatic run_step(input logic [1:0] s1, input logic s2, input logic l1, input logic l2,
                          input logic e_oc, input int idle);
    ld_a = 1'b1; sel1 = s1; sel2 = s2;
    tick;
    ld_a = 1'b0;
    repeat (idle) tick;
    ld_r = 1'b1; lock1 = l1; lock2 = l2; eoc = e_oc;
    tick;
    ld_r = 1'b0; lock1 = 1'b0; lock2 = 1'b0; eoc = 1'b0;
  endtask

  task automatic run_exp(input logic [3:0] e);
    pulse_rst_mmm;
    done_seen = 0;
    run_step(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 10);
    for (int i = 0; i < 4; i++) run_step(2'b01, 1'b1, e[i], 1'b1, 1'b0, 10);
    run_step(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 10);
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    #1;
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dut.r_x !== 8'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", dut.r_x); end
    checks++; if (dut.r_p !== 8'd0) begin failures++; $display("FAIL reset_p got=%0d exp=0", dut.r_p); end
    tick;
    rstb = 1'b1;
    tick;
  endtask

  task automatic test_single_mult;
    pulse_rst_mmm;
    run_step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8);
    checks++; if (dut.r_x !== 8'd25) begin failures++; $display("FAIL single_x got=%0d exp=25", dut.r_x); end
    checks++; if (dut.r_p !== 8'd0) begin failures++; $display("FAIL single_p_held got=%0d exp=0", dut.r_p); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done got=%b exp=0", done); end
    ld_r = 1'b1; lock1 = 1'b1; lock2 = 1'b1;
    tick;
    ld_r = 1'b0; lock1 = 1'b0; lock2 = 1'b0;
    checks++; if (dut.r_x !== 8'd25) begin failures++; $display("FAIL single_rewrite_x got=%0d exp=25", dut.r_x); end
    checks++; if (dut.r_p !== 8'd1) begin failures++; $display("FAIL single_p_mr got=%0d exp=1", dut.r_p); end
  endtask

  task automatic test_loop_step;
    run_step(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 10);
    checks++; if (dut.r_x !== 8'd25) begin failures++; $display("FAIL loop_x_kept got=%0d exp=25", dut.r_x); end
    checks++; if (dut.r_p !== 8'd4) begin failures++; $display("FAIL loop_p_sq got=%0d exp=4", dut.r_p); end
    run_step(2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 10);
    checks++; if (dut.r_x !== 8'd1) begin failures++; $display("FAIL sel11_x got=%0d exp=1", dut.r_x); end
    checks++; if (result !== 8'd1) begin failures++; $display("FAIL sel11_result got=%0d exp=1", result); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL sel11_done got=%b exp=1", done); end
    tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_ld_priority;
    ld_a = 1'b1; ld_r = 1'b1; lock2 = 1'b1; sel1 = 2'b01; sel2 = 1'b1;
    tick;
    ld_a = 1'b0; ld_r = 1'b0; lock2 = 1'b0;
    checks++; if (dut.r_p !== 8'd4) begin failures++; $display("FAIL lda_wins_p got=%0d exp=4", dut.r_p); end
    repeat (8) tick;
    ld_r = 1'b1; lock2 = 1'b1;
    tick;
    ld_r = 1'b0; lock2 = 1'b0;
    checks++; if (dut.r_p !== 8'd31) begin failures++; $display("FAIL sq_after_collision got=%0d exp=31", dut.r_p); end
    checks++; if (dut.r_x !== 8'd1) begin failures++; $display("FAIL x_no_lock got=%0d exp=1", dut.r_x); end
  endtask

  task automatic test_early_ldr;
    pulse_rst_mmm;
    run_step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    checks++; if (dut.r_x !== 8'd2) begin failures++; $display("FAIL early_partial_x got=%0d exp=2", dut.r_x); end
`ifdef MMM_SCHED_CHECK_EN
    checks++; if (sched_err !== 1'b1) begin failures++; $display("FAIL sched_err_set got=%b exp=1", sched_err); end
    repeat (3) tick;
    checks++; if (sched_err !== 1'b1) begin failures++; $display("FAIL sched_err_sticky got=%b exp=1", sched_err); end
    pulse_rst_mmm;
    checks++; if (sched_err !== 1'b0) begin failures++; $display("FAIL sched_err_clear got=%b exp=0", sched_err); end
`endif
  endtask

  task automatic test_full_exp;
    run_exp(4'd13);
    checks++; if (result !== 8'd31) begin failures++; $display("FAIL exp13_result got=%0d exp=31", result); end
    checks++; if (done_seen !== 1) begin failures++; $display("FAIL exp13_done_pulses got=%0d exp=1", done_seen); end
    run_exp(4'd0);
    checks++; if (result !== 8'd1) begin failures++; $display("FAIL exp0_result got=%0d exp=1", result); end
    run_exp(4'd1);
    checks++; if (result !== 8'd4) begin failures++; $display("FAIL exp1_result got=%0d exp=4", result); end
    checks++; if (done_seen !== 1) begin failures++; $display("FAIL exp1_done_pulses got=%0d exp=1", done_seen); end
  endtask

  task automatic test_en_hold;
    pulse_rst_mmm;
    ld_a = 1'b1; sel1 = 2'b00;
    tick;
    ld_a = 1'b0;
    repeat (2) tick;
    en = 1'b0; ld_r = 1'b1; lock1 = 1'b1; eoc = 1'b1;
    repeat (3) tick;
    checks++; if (dut.r_cnt1 !== 4'd2) begin failures++; $display("FAIL en_cnt_hold got=%0d exp=2", dut.r_cnt1); end
    checks++; if (dut.r_x !== 8'd4) begin failures++; $display("FAIL en_x_hold got=%0d exp=4", dut.r_x); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL en_done_low got=%b exp=0", done); end
    en = 1'b1; ld_r = 1'b0; lock1 = 1'b0; eoc = 1'b0;
    tick;
    eoc = 1'b1;
    tick;
    en = 1'b0;
    tick;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL en_forces_done got=%b exp=0", done); end
    checks++; if (result !== 8'd4) begin failures++; $display("FAIL en_result_hold got=%0d exp=4", result); end
    en = 1'b1; eoc = 1'b0;
    tick;
  endtask

  task automatic test_eoc_hold;
    done_seen = 0;
    eoc = 1'b1;
    repeat (3) tick;
    eoc = 1'b0;
    tick;
    checks++; if (done_seen !== 3) begin failures++; $display("FAIL eoc_hold_pulses got=%0d exp=3", done_seen); end
    checks++; if (result !== 8'd4) begin failures++; $display("FAIL eoc_hold_result got=%0d exp=4", result); end
  endtask

  task automatic test_async_reset;
    run_exp(4'd13);
    pulse_rst_mmm;
    ld_a = 1'b1; sel1 = 2'b00; sel2 = 1'b0;
    tick;
    ld_a = 1'b0; eoc = 1'b1;
    repeat (4) tick;
    eoc = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL pre_rst_done got=%b exp=1", done); end
    rstb = 1'b0;
    #1;
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL arst_result got=%0d exp=0", result); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", done); end
    checks++; if (dut.r_x !== 8'd0) begin failures++; $display("FAIL arst_x got=%0d exp=0", dut.r_x); end
    checks++; if (dut.r_p !== 8'd0) begin failures++; $display("FAIL arst_p got=%0d exp=0", dut.r_p); end
    checks++; if (dut.r_cnt1 !== 4'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", dut.r_cnt1); end
    @(posedge clk);
    #1;
    rstb = 1'b1;
    tick;
    run_exp(4'd13);
    checks++; if (result !== 8'd31) begin failures++; $display("FAIL rerun_result got=%0d exp=31", result); end
  endtask

  initial begin
    rstb = 1'b1; en = 1'b1; rst_mmm = 1'b1; ld_a = 1'b0; ld_r = 1'b0;
    lock1 = 1'b0; lock2 = 1'b0; sel1 = 2'b00; sel2 = 1'b0; eoc = 1'b0;
    msg = 8'd4; modn = 8'd33; r2_mod = 8'd31;
    test_reset;
    test_single_mult;
    test_loop_step;
    test_ld_priority;
    test_early_ldr;
    test_full_exp;
    test_en_hold;
    test_eoc_hold;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
